// File: rtl/fencing_score_keeper.sv
// Fencing score keeper: turns per-frame saber collision flags into confirmed touches,
// scores, round-reset pulses and a game-over result, with glitch filter and lockout.
module fencing_score_keeper #(
  parameter int unsigned SCORE_W        = 4,
  parameter int unsigned WIN_SCORE      = 5,
  parameter int unsigned CONFIRM_FRAMES = 3,
  parameter int unsigned LOCKOUT_FRAMES = 60
) (
  input  logic               clk_pixel_in,
  input  logic               rst_in,
  input  logic               new_frame_in,
  input  logic               start_in,
  input  logic               p1_colliding,
  input  logic               p2_colliding,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               point_p1,
  output logic               point_p2,
  output logic               round_reset,
  output logic               in_play,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam int unsigned CntW  = $clog2(CONFIRM_FRAMES + 1);
  localparam int unsigned LockW = $clog2(LOCKOUT_FRAMES + 1);

  localparam logic [CntW-1:0]    CntLast  = CntW'(CONFIRM_FRAMES - 1);
  localparam logic [LockW-1:0]   LockInit = LockW'(LOCKOUT_FRAMES);
  localparam logic [LockW-1:0]   LockOne  = LockW'(1);
  localparam logic [SCORE_W-1:0] WinVal   = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {StIdle, StPlay, StLockout, StGameOver} state_e;

  state_e             state_q, state_d;
  logic               seen1_q, seen1_d, seen2_q, seen2_d;
  logic [CntW-1:0]    cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [LockW-1:0]   lock_q, lock_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic               point1_q, point1_d, point2_q, point2_d, rr_q, rr_d;
  logic               in_play_q, in_play_d, game_over_q, game_over_d;
  logic [1:0]         winner_q, winner_d;

  logic hit1, hit2, confirm1, confirm2;

  // The hit of the frame includes the evaluation cycle itself.
  assign hit1     = seen1_q | p1_colliding;
  assign hit2     = seen2_q | p2_colliding;
  assign confirm1 = hit1 && (cnt1_q == CntLast);
  assign confirm2 = hit2 && (cnt2_q == CntLast);

  always_comb begin
    state_d  = state_q;
    seen1_d  = 1'b0;
    seen2_d  = 1'b0;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    lock_d   = lock_q;
    score1_d = score1_q;
    score2_d = score2_q;
    point1_d = 1'b0;
    point2_d = 1'b0;
    rr_d     = 1'b0;
    winner_d = winner_q;

    unique case (state_q)
      StIdle, StGameOver: begin
        if (start_in) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = 2'd0;
          cnt1_d   = '0;
          cnt2_d   = '0;
          lock_d   = '0;
          state_d  = StPlay;
        end
      end
      StPlay: begin
        if (new_frame_in) begin
          cnt1_d = hit1 ? cnt1_q + 1'b1 : '0;
          cnt2_d = hit2 ? cnt2_q + 1'b1 : '0;
          if (confirm1 || confirm2) begin
            rr_d    = 1'b1;
            cnt1_d  = '0;
            cnt2_d  = '0;
            lock_d  = LockInit;
            state_d = StLockout;
            if (confirm1 && !confirm2) begin
              score1_d = score1_q + 1'b1;
              point1_d = 1'b1;
              if (score1_d == WinVal) begin
                state_d  = StGameOver;
                winner_d = 2'd1;
              end
            end else if (confirm2 && !confirm1) begin
              score2_d = score2_q + 1'b1;
              point2_d = 1'b1;
              if (score2_d == WinVal) begin
                state_d  = StGameOver;
                winner_d = 2'd2;
              end
            end
          end
        end else begin
          seen1_d = seen1_q | p1_colliding;
          seen2_d = seen2_q | p2_colliding;
        end
      end
      StLockout: begin
        if (new_frame_in) begin
          lock_d = lock_q - 1'b1;
          if (lock_q == LockOne) state_d = StPlay;
        end
      end
      default: state_d = StIdle;
    endcase

    in_play_d   = (state_d == StPlay);
    game_over_d = (state_d == StGameOver);
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      seen1_q     <= 1'b0;
      seen2_q     <= 1'b0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      lock_q      <= '0;
      score1_q    <= '0;
      score2_q    <= '0;
      point1_q    <= 1'b0;
      point2_q    <= 1'b0;
      rr_q        <= 1'b0;
      in_play_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      seen1_q     <= seen1_d;
      seen2_q     <= seen2_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      lock_q      <= lock_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      point1_q    <= point1_d;
      point2_q    <= point2_d;
      rr_q        <= rr_d;
      in_play_q   <= in_play_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign p1_score    = score1_q;
  assign p2_score    = score2_q;
  assign point_p1    = point1_q;
  assign point_p2    = point2_q;
  assign round_reset = rr_q;
  assign in_play     = in_play_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_fencing_score_keeper.sv
// Scoreboard bench for fencing_score_keeper: expected touch events are queued by the
// stimulus and popped by a monitor whenever the DUT emits a point/round_reset pulse.
module tb_fencing_score_keeper;

  logic       clk, rst, nf, start, p1, p2;
  logic [3:0] p1_score, p2_score;
  logic       point_p1, point_p2, round_reset, in_play, game_over;
  logic [1:0] winner;

  int tests = 0;
  int fails = 0;
  logic [13:0] exp_q[$];

  fencing_score_keeper dut (
    .clk_pixel_in (clk),
    .rst_in       (rst),
    .new_frame_in (nf),
    .start_in     (start),
    .p1_colliding (p1),
    .p2_colliding (p2),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .point_p1     (point_p1),
    .point_p2     (point_p2),
    .round_reset  (round_reset),
    .in_play      (in_play),
    .game_over    (game_over),
    .winner       (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [13:0] mk(input logic pp1, input logic pp2, input logic rr,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic go, input logic [1:0] win);
    return {pp1, pp2, rr, s1, s2, go, win};
  endfunction

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (point_p1 || point_p2 || round_reset)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event actual=%0h required=none",
                 {point_p1, point_p2, round_reset, p1_score, p2_score, game_over, winner});
      end else begin
        check("event", {18'd0, point_p1, point_p2, round_reset, p1_score, p2_score, game_over,
                        winner}, {18'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic h1, input logic h2);
    p1 = h1;
    p2 = h2;
    repeat (3) cycle();
    nf = 1'b1;
    cycle();
    nf = 1'b0;
    p1 = 1'b0;
    p2 = 1'b0;
  endtask

  task automatic glitch_frame();
    cycle();
    p1 = 1'b1;
    cycle();
    p1 = 1'b0;
    cycle();
    nf = 1'b1;
    cycle();
    nf = 1'b0;
  endtask

  task automatic lockout();
    repeat (60) frame(1'b0, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic touch(input int who, input logic [3:0] e1, input logic [3:0] e2,
                       input logic go, input logic [1:0] win, input bit do_lock);
    exp_q.push_back(mk(who == 1, who == 2, 1'b1, e1, e2, go, win));
    repeat (3) frame(who == 1, who == 2);
    if (do_lock) lockout();
  endtask

  initial begin
    rst = 1'b1; nf = 1'b0; start = 1'b0; p1 = 1'b0; p2 = 1'b0;
    cycle();
    repeat (3) cycle();
    rst = 1'b0;
    check("rst_p1_score", p1_score, 0);
    check("rst_p2_score", p2_score, 0);
    check("rst_in_play", in_play, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);

    // 1: first P1 touch and full lockout duration
    pulse_start();
    check("t1_in_play", in_play, 1);
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    exp_q.push_back(mk(1, 0, 1, 4'd1, 4'd0, 0, 2'd0));
    frame(1'b1, 1'b0);
    check("t1_p1_score", p1_score, 1);
    for (int i = 0; i < 60; i++) begin
      check("t1_lockout_in_play", in_play, 0);
      frame(1'b1, 1'b0);
    end
    check("t1_in_play_after", in_play, 1);

    // 2: a gap resets the confirm count
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    check("t2_no_point", p1_score, 1);
    exp_q.push_back(mk(1, 0, 1, 4'd2, 4'd0, 0, 2'd0));
    frame(1'b1, 1'b0);
    check("t2_p1_score", p1_score, 2);
    lockout();

    // 3: double touch
    exp_q.push_back(mk(0, 0, 1, 4'd2, 4'd0, 0, 2'd0));
    repeat (3) frame(1'b1, 1'b1);
    check("t3_p1_score", p1_score, 2);
    check("t3_p2_score", p2_score, 0);
    check("t3_in_play", in_play, 0);
    lockout();

    // 4: one-cycle glitches mid-frame are captured by the sticky bit
    exp_q.push_back(mk(1, 0, 1, 4'd3, 4'd0, 0, 2'd0));
    repeat (3) glitch_frame();
    check("t4_p1_score", p1_score, 3);
    lockout();

    // 5: P2 wins
    for (int k = 1; k <= 4; k++) touch(2, 4'd3, 4'(k), 1'b0, 2'd0, 1'b1);
    touch(2, 4'd3, 4'd5, 1'b1, 2'd2, 1'b0);
    check("t5_game_over", game_over, 1);
    check("t5_winner", winner, 2);
    check("t5_p2_score", p2_score, 5);
    repeat (3) frame(1'b1, 1'b1);
    check("t5_ignored_p1", p1_score, 3);
    check("t5_ignored_p2", p2_score, 5);
    pulse_start();
    check("t5_restart_p1", p1_score, 0);
    check("t5_restart_p2", p2_score, 0);
    check("t5_restart_in_play", in_play, 1);
    check("t5_restart_game_over", game_over, 0);
    check("t5_restart_winner", winner, 0);

    // 6: reset in the middle of a lockout at 3-2
    for (int k = 1; k <= 3; k++) touch(1, 4'(k), 4'd0, 1'b0, 2'd0, 1'b1);
    touch(2, 4'd3, 4'd1, 1'b0, 2'd0, 1'b1);
    touch(2, 4'd3, 4'd2, 1'b0, 2'd0, 1'b0);
    repeat (5) frame(1'b0, 1'b0);
    check("t6_pre_p1", p1_score, 3);
    check("t6_pre_p2", p2_score, 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_rst_scores", {p1_score, p2_score}, 0);
    check("t6_rst_flags", {point_p1, point_p2, round_reset, in_play, game_over, winner}, 0);
    repeat (4) frame(1'b1, 1'b0);
    check("t6_idle_p1", p1_score, 0);
    check("t6_idle_in_play", in_play, 0);
    pulse_start();
    touch(1, 4'd1, 4'd0, 1'b0, 2'd0, 1'b0);

    repeat (4) cycle();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
